// File: rtl/fetch_stage.sv
// fetch_stage: single-outstanding instruction fetch with a one-entry hold buffer,
// decode-stage registers and delayed (branch-delay-slot) redirect handling.
module fetch_stage (
    input  logic        clk,
    input  logic        resetn,
    output logic        ireq,
    output logic [31:0] iaddr,
    input  logic        iaddr_ok,
    input  logic        idata_ok,
    input  logic [31:0] idata,
    input  logic        D_stall,
    input  logic        d_jump,
    input  logic [31:0] d_target,
    output logic        D_valid,
    output logic [31:0] D_pc,
    output logic [5:0]  D_icode,
    output logic [4:0]  D_rs,
    output logic [4:0]  D_rt,
    output logic [4:0]  D_rd,
    output logic [4:0]  D_sa,
    output logic [5:0]  D_acode,
    output logic [31:0] f_pc,
    output logic [31:0] pred_pc
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;
    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic [1:0]  state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] iaddr_q, iaddr_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic        redir_valid_q, redir_valid_d;
    logic        d_valid_q, d_valid_d;
    logic [31:0] d_pc_q, d_pc_d;
    logic [31:0] ir_q, ir_d;
    logic        slot_free, data_in, deliver, redir_now, redir_any;
    logic [31:0] word, redir_tgt, next_pc;

    always_comb begin
        slot_free = !d_valid_q || !D_stall;
        data_in   = idata_ok && (state_q == WAIT || (state_q == REQ && iaddr_ok));
        deliver   = (data_in && slot_free) || (state_q == HOLD && !D_stall);
        word      = (state_q == HOLD) ? buf_q : idata;
        redir_now = d_jump && d_valid_q && !D_stall;
        redir_any = redir_now || redir_valid_q;
        redir_tgt = redir_now ? d_target : redir_pc_q;
        // The word delivered while a redirect is pending is the delay slot; its successor is the target.
        next_pc   = redir_any ? redir_tgt : iaddr_q + 32'd4;
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        iaddr_d       = iaddr_q;
        buf_d         = buf_q;
        redir_valid_d = redir_any;
        redir_pc_d    = redir_tgt;
        if (state_q == IDLE) begin
            state_d = REQ;
            iaddr_d = fetch_pc_q;
        end else if (deliver) begin
            state_d       = REQ;
            iaddr_d       = next_pc;
            fetch_pc_d    = next_pc;
            redir_valid_d = 1'b0;
        end else if (data_in) begin
            state_d = HOLD;
            buf_d   = idata;
        end else if (state_q == REQ && iaddr_ok) begin
            state_d = WAIT;
        end
        d_valid_d = deliver || (D_stall && d_valid_q);
        d_pc_d    = deliver ? iaddr_q : d_pc_q;
        ir_d      = deliver ? word : (D_stall ? ir_q : 32'd0);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            fetch_pc_q    <= RESET_PC;
            iaddr_q       <= RESET_PC;
            buf_q         <= 32'd0;
            redir_pc_q    <= 32'd0;
            redir_valid_q <= 1'b0;
            d_valid_q     <= 1'b0;
            d_pc_q        <= RESET_PC - 32'd4;
            ir_q          <= 32'd0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            iaddr_q       <= iaddr_d;
            buf_q         <= buf_d;
            redir_pc_q    <= redir_pc_d;
            redir_valid_q <= redir_valid_d;
            d_valid_q     <= d_valid_d;
            d_pc_q        <= d_pc_d;
            ir_q          <= ir_d;
        end
    end

    assign ireq    = state_q == REQ;
    assign iaddr   = iaddr_q;
    assign D_valid = d_valid_q;
    assign D_pc    = d_pc_q;
    assign D_icode = ir_q[31:26];
    assign D_rs    = ir_q[25:21];
    assign D_rt    = ir_q[20:16];
    assign D_rd    = ir_q[15:11];
    assign D_sa    = ir_q[10:6];
    assign D_acode = ir_q[5:0];
    assign f_pc    = d_pc_q + 32'd4;
    assign pred_pc = d_pc_q + 32'd8;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized bus/decoder stimulus checked against a program-order
// reference model of deliveries, hold buffering, bubbles and delayed redirects.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        ireq, iaddr_ok = 1'b0, idata_ok = 1'b0, D_stall = 1'b0, d_jump = 1'b0, D_valid;
    logic [31:0] iaddr, idata = 32'd0, d_target = 32'd0, D_pc, f_pc, pred_pc;
    logic [5:0]  D_icode, D_acode;
    logic [4:0]  D_rs, D_rt, D_rd, D_sa;

    fetch_stage dut (
        .clk(clk), .resetn(resetn), .ireq(ireq), .iaddr(iaddr), .iaddr_ok(iaddr_ok),
        .idata_ok(idata_ok), .idata(idata), .D_stall(D_stall), .d_jump(d_jump),
        .d_target(d_target), .D_valid(D_valid), .D_pc(D_pc), .D_icode(D_icode),
        .D_rs(D_rs), .D_rt(D_rt), .D_rd(D_rd), .D_sa(D_sa), .D_acode(D_acode),
        .f_pc(f_pc), .pred_pc(pred_pc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int unsigned stall_pct, acc_pct, jump_pct, lat_lo, lat_hi, lat;
    bit same_ok, pending, hold_v, e_valid, e_jump, started, redir_p, saw_lui;
    logic [31:0] exp_req, pend_addr, acc_addr, hold_pc, hold_word, e_pc, e_word, redir_tgt, jt_target;
    logic [31:0] deliv[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'hBFC0_0004) ? 32'h3C08_ABCD : (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
    endfunction

    task automatic model_reset();
        pending = 0; hold_v = 0; e_valid = 0; e_jump = 0; started = 0; redir_p = 0;
        e_pc = 32'hBFBF_FFFC; e_word = 0; exp_req = 32'hBFC0_0000; jt_target = 0;
    endtask

    task automatic load(input logic [31:0] pc, input logic [31:0] w);
        bit dly;
        dly = redir_p;
        e_valid = 1; e_pc = pc; e_word = w;
        deliv.push_back(pc);
        exp_req = redir_p ? redir_tgt : pc + 32'd4;
        redir_p = 0;
        e_jump = !dly && (pc == 32'hBFC0_0010 || $urandom_range(99) < jump_pct);
        jt_target = (pc == 32'hBFC0_0010) ? 32'hBFC0_0100 :
                    ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 : ($urandom & ~32'd3);
    endtask

    task automatic drive();
        D_stall  = $urandom_range(99) < stall_pct;
        d_jump   = e_valid && e_jump;
        d_target = jt_target;
        idata_ok = pending && lat == 0;
        idata    = idata_ok ? mem_word(pend_addr) : $urandom;
        iaddr_ok = 0;
        if (ireq && !pending && $urandom_range(99) < acc_pct) begin
            iaddr_ok = 1;
            acc_addr = iaddr;
            lat = $urandom_range(lat_hi, lat_lo);
            if (same_ok && $urandom_range(1) == 1) begin
                idata_ok = 1;
                idata = mem_word(iaddr);
            end
        end
    endtask

    task automatic tick();
        logic inc;
        logic [31:0] inc_pc, inc_w;
        @(posedge clk);
        inc = 0; inc_pc = 0; inc_w = idata;
        if (d_jump && e_valid && !D_stall) begin
            redir_p = 1;
            redir_tgt = d_target;
        end
        if (iaddr_ok && idata_ok) begin
            inc = 1; inc_pc = acc_addr;
        end else if (iaddr_ok) begin
            pending = 1; pend_addr = acc_addr;
        end else if (idata_ok) begin
            inc = 1; inc_pc = pend_addr; pending = 0;
        end else if (pending && lat > 0) lat--;
        if (hold_v && !D_stall) begin
            hold_v = 0;
            load(hold_pc, hold_word);
        end else if (inc && (!e_valid || !D_stall)) load(inc_pc, inc_w);
        else if (inc) begin
            hold_v = 1; hold_pc = inc_pc; hold_word = inc_w;
        end else if (!D_stall) begin
            e_valid = 0; e_word = 0; e_jump = 0;
        end
        started = 1;
        #1;
        chk("d_valid", {31'd0, D_valid}, {31'd0, e_valid});
        chk("d_pc", D_pc, e_pc);
        chk("d_fields", {D_icode, D_rs, D_rt, D_rd, D_sa, D_acode}, e_word);
        chk("f_pc", f_pc, e_pc + 32'd4);
        chk("pred_pc", pred_pc, e_pc + 32'd8);
        chk("ireq", {31'd0, ireq}, {31'd0, started && !pending && !hold_v});
        if (ireq) chk("iaddr", iaddr, exp_req);
        drive();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ireq"}, {31'd0, ireq}, 32'd0);
        chk({tag, "_iaddr"}, iaddr, 32'hBFC0_0000);
        chk({tag, "_dvalid"}, {31'd0, D_valid}, 32'd0);
        chk({tag, "_dpc"}, D_pc, 32'hBFBF_FFFC);
        chk({tag, "_fields"}, {D_icode, D_rs, D_rt, D_rd, D_sa, D_acode}, 32'd0);
        chk({tag, "_fpc"}, f_pc, 32'hBFC0_0000);
        chk({tag, "_predpc"}, pred_pc, 32'hBFC0_0004);
    endtask

    initial begin
        stall_pct = 0; acc_pct = 100; jump_pct = 0; lat_lo = 0; lat_hi = 0; lat = 0; same_ok = 0;
        saw_lui = 0; acc_addr = 0; pend_addr = 0; hold_pc = 0; hold_word = 0; redir_tgt = 0;
        model_reset();
        #1 resetn = 1'b0;
        #2 chk_reset_outputs("rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        deliv.delete();
        // Zero-wait memory, no stalls: sequential fetch plus the forced jump at 0xBFC00010.
        for (int i = 0; i < 22; i++) begin
            tick();
            if (e_valid && e_pc == 32'hBFC0_0004 && !saw_lui) begin
                saw_lui = 1;
                chk("lui_icode", {26'd0, D_icode}, 32'h0F);
                chk("lui_rs", {27'd0, D_rs}, 32'h00);
                chk("lui_rt", {27'd0, D_rt}, 32'h08);
                chk("lui_rd", {27'd0, D_rd}, 32'h15);
                chk("lui_sa", {27'd0, D_sa}, 32'h0F);
                chk("lui_acode", {26'd0, D_acode}, 32'h0D);
                chk("lui_pred", pred_pc, 32'hBFC0_000C);
            end
        end
        chk("saw_lui", {31'd0, saw_lui}, 32'd1);
        chk("deliv_cnt", {31'd0, deliv.size() >= 7}, 32'd1);
        if (deliv.size() >= 7) begin
            chk("seq0", deliv[0], 32'hBFC0_0000);
            chk("seq1", deliv[1], 32'hBFC0_0004);
            chk("seq2", deliv[2], 32'hBFC0_0008);
            chk("seq_jump", deliv[4], 32'hBFC0_0010);
            chk("seq_delay", deliv[5], 32'hBFC0_0014);
            chk("seq_target", deliv[6], 32'hBFC0_0100);
        end
        // Decode stalled long enough that the next word must sit in the hold buffer.
        stall_pct = 100;
        repeat (6) tick();
        chk("hold_ireq", {31'd0, ireq}, 32'd0);
        chk("hold_dvalid", {31'd0, D_valid}, 32'd1);
        chk("hold_buffered", {31'd0, hold_v}, 32'd1);
        stall_pct = 0;
        repeat (3) tick();
        // Fixed 3-cycle data latency with frequent jumps.
        lat_lo = 3; lat_hi = 3; jump_pct = 30;
        repeat (200) tick();
        // Fully random bus, stalls, jumps and same-cycle address/data acceptance.
        lat_lo = 0; lat_hi = 3; acc_pct = 70; stall_pct = 40; same_ok = 1;
        repeat (600) tick();
        // Reset asserted mid-transaction.
        acc_pct = 100; stall_pct = 0; same_ok = 0; lat_lo = 3;
        for (int i = 0; i < 20 && !pending; i++) tick();
        chk("pend_before_rst", {31'd0, pending}, 32'd1);
        #2;
        resetn = 1'b0;
        iaddr_ok = 0; idata_ok = 0; D_stall = 0; d_jump = 0;
        #1 chk_reset_outputs("midrst");
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        lat_lo = 0; stall_pct = 30; acc_pct = 80; same_ok = 1;
        repeat (150) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
